midi_rx_decoder: RTL

MIDI_RX_DECODER -- requirements
Module: midi_rx_decoder

---
 rtl/midi_pkg.sv | 37 +++
 rtl/midi_uart_rx.sv | 98 +++++++++
 rtl/midi_rx_decoder.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/midi_pkg.sv
// Shared MIDI constants, state enums and the message-length helper for the MIDI receiver.
// Optional running-status support in midi_rx_decoder is selected by MIDI_RX_RUNNING_STATUS_EN.
package midi_pkg;

    localparam logic [3:0] NOTE_OFF    = 4'h8;
    localparam logic [3:0] NOTE_ON     = 4'h9;
    localparam logic [3:0] POLY_AT     = 4'hA;
    localparam logic [3:0] CC          = 4'hB;
    localparam logic [3:0] PROG_CHANGE = 4'hC;
    localparam logic [3:0] CHAN_AT     = 4'hD;
    localparam logic [3:0] PITCH_BEND  = 4'hE;

    localparam logic [6:0] CC_VOLUME = 7'd7;

    typedef enum logic [1:0] {
        PS_WAIT,
        PS_DATA1,
        PS_DATA2
    } parser_state_e;

    typedef enum logic [1:0] {
        US_IDLE,
        US_START,
        US_DATA,
        US_STOP
    } uart_state_e;

    // True when a channel voice status with this high nibble carries two data bytes.
    function automatic logic has_two_data(input logic [3:0] nib);
        case (nib)
            NOTE_OFF, NOTE_ON, POLY_AT, CC, PITCH_BEND: return 1'b1;
            PROG_CHANGE, CHAN_AT:                       return 1'b0;
            default:                                    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/midi_uart_rx.sv
// 8N1 UART receiver: synchronizes rx, rejects start glitches, delivers one byte per valid stop bit.
// byte_valid and frame_err are single-cycle strobes on the stop-bit sample cycle.
module midi_uart_rx
    import midi_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 31_250
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] byte_o,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int DIV  = CLK_HZ / BAUD;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV);

    uart_state_e   state_q, state_d;
    logic [1:0]    sync_q;
    logic [1:0]    live_q;
    logic          rx_prev_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;

    logic          rx_s;
    logic          start_edge;
    logic          tick;

    assign rx_s = sync_q[1];
    // rx_prev_q only goes high once the chain holds a real sample, so a line
    // held low through reset release never looks like a start edge.
    assign start_edge = rx_prev_q & ~rx_s;
    assign tick = (cnt_q == ((state_q == US_START) ? CW'(HALF - 1) : CW'(DIV - 1)));

    // NOTE: every flop here uses non-blocking assignment so all state updates see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= 2'b11;
            live_q    <= 2'b00;
            rx_prev_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], rx};
            live_q    <= {live_q[0], 1'b1};
            rx_prev_q <= rx_s & live_q[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= US_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            if (state_q == US_IDLE || tick) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (state_q == US_START) begin
                bit_q <= '0;
            end else if (state_q == US_DATA && tick) begin
                shift_q <= {rx_s, shift_q[7:1]};
                bit_q   <= bit_q + 1'b1;
            end
        end
    end

    // NOTE: state_d takes a default first so no path through the case infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            US_IDLE:  if (start_edge)             state_d = US_START;
            US_START: if (tick)                   state_d = rx_s ? US_IDLE : US_DATA;
            US_DATA:  if (tick && bit_q == 3'd7)  state_d = US_STOP;
            US_STOP:  if (tick)                   state_d = US_IDLE;
            default:                              state_d = US_IDLE;
        endcase
    end

    always_comb begin
        byte_o     = shift_q;
        byte_valid = (state_q == US_STOP) && tick && rx_s;
        frame_err  = (state_q == US_STOP) && tick && !rx_s;
    end

endmodule

// File: rtl/midi_rx_decoder.sv
// MIDI receiver: UART front end plus a channel-voice parser driving a 10-key bitmap and CC7 volume.
// Define MIDI_RX_RUNNING_STATUS_EN to accept data bytes under a previously stored status.
module midi_rx_decoder
    import midi_pkg::*;
#(
    parameter int CLK_HZ    = 100_000_000,
    parameter int BAUD      = 31_250,
    parameter int BASE_NOTE = 60,
    parameter int CHANNEL   = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [9:0] keys,
    output logic [7:0] volume,
    output logic       note_valid,
    output logic       note_on,
    output logic [6:0] note_num,
    output logic [6:0] note_vel,
    output logic       frame_err
);

`ifdef MIDI_RX_RUNNING_STATUS_EN
    localparam parser_state_e DONE_STATE = PS_DATA1;
`else
    localparam parser_state_e DONE_STATE = PS_WAIT;
`endif

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_ferr;

    midi_uart_rx #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) u_uart (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .byte_o     (rx_byte),
        .byte_valid (rx_valid),
        .frame_err  (rx_ferr)
    );

    parser_state_e state_q, state_d;
    logic [7:0]    status_q, status_d;
    logic          rs_valid_q, rs_valid_d;
    logic [6:0]    data1_q, data1_d;
    logic [9:0]    keys_q, keys_d;
    logic [7:0]    volume_q, volume_d;
    logic          note_valid_q, note_valid_d;
    logic          note_on_q, note_on_d;
    logic [6:0]    note_num_q, note_num_d;
    logic [6:0]    note_vel_q, note_vel_d;
    logic          frame_err_q, frame_err_d;

    logic          accept_first;
    logic          complete;
    logic [6:0]    msg_d1;
    logic [6:0]    msg_d2;
    logic          is_on;
    int            key_ofs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PS_WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_q     <= '0;
            rs_valid_q   <= 1'b0;
            data1_q      <= '0;
            keys_q       <= '0;
            volume_q     <= 8'h80;
            note_valid_q <= 1'b0;
            note_on_q    <= 1'b0;
            note_num_q   <= '0;
            note_vel_q   <= '0;
            frame_err_q  <= 1'b0;
        end else begin
            status_q     <= status_d;
            rs_valid_q   <= rs_valid_d;
            data1_q      <= data1_d;
            keys_q       <= keys_d;
            volume_q     <= volume_d;
            note_valid_q <= note_valid_d;
            note_on_q    <= note_on_d;
            note_num_q   <= note_num_d;
            note_vel_q   <= note_vel_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // Byte classification and next parser state.
    always_comb begin
        state_d      = state_q;
        status_d     = status_q;
        rs_valid_d   = rs_valid_q;
        data1_d      = data1_q;
        accept_first = 1'b0;
        complete     = 1'b0;
        msg_d1       = data1_q;
        msg_d2       = rx_byte[6:0];

        if (rx_valid) begin
            if (rx_byte >= 8'hF8) begin
                // realtime: transparent to the parser
            end else if (rx_byte >= 8'hF0) begin
                rs_valid_d = 1'b0;
                state_d    = PS_WAIT;
            end else if (rx_byte[7]) begin
                status_d   = rx_byte;
                rs_valid_d = 1'b1;
                state_d    = PS_DATA1;
            end else begin
                case (state_q)
                    PS_WAIT: begin
`ifdef MIDI_RX_RUNNING_STATUS_EN
                        accept_first = rs_valid_q;
`endif
                    end
                    PS_DATA1: accept_first = rs_valid_q;
                    PS_DATA2: complete     = 1'b1;
                    default:  state_d      = PS_WAIT;
                endcase
            end

            if (accept_first) begin
                if (has_two_data(status_q[7:4])) begin
                    data1_d = rx_byte[6:0];
                    state_d = PS_DATA2;
                end else begin
                    complete = 1'b1;
                    msg_d1   = rx_byte[6:0];
                end
            end

            if (complete) begin
                state_d = DONE_STATE;
            end
        end
    end

    // Message actions on completion of a channel-matched message.
    always_comb begin
        keys_d       = keys_q;
        volume_d     = volume_q;
        note_valid_d = 1'b0;
        note_on_d    = note_on_q;
        note_num_d   = note_num_q;
        note_vel_d   = note_vel_q;
        frame_err_d  = rx_ferr;
        is_on        = (status_q[7:4] == NOTE_ON) && (msg_d2 != 7'd0);
        key_ofs      = int'(msg_d1) - BASE_NOTE;

        if (complete && status_q[3:0] == 4'(CHANNEL)) begin
            case (status_q[7:4])
                NOTE_OFF, NOTE_ON: begin
                    note_valid_d = 1'b1;
                    note_on_d    = is_on;
                    note_num_d   = msg_d1;
                    note_vel_d   = msg_d2;
                    if (key_ofs >= 0 && key_ofs < 10) begin
                        keys_d[key_ofs[3:0]] = is_on;
                    end
                end
                CC: begin
                    if (msg_d1 == CC_VOLUME) begin
                        volume_d = {msg_d2, 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end

    assign keys       = keys_q;
    assign volume     = volume_q;
    assign note_valid = note_valid_q;
    assign note_on    = note_on_q;
    assign note_num   = note_num_q;
    assign note_vel   = note_vel_q;
    assign frame_err  = frame_err_q;

endmodule
